// File: rtl/input_conditioner.sv
// input_conditioner: front end for the two player push-buttons.
// Each raw pad goes through a synchroniser and a debouncer. The up button also
// feeds a press latch that holds a short tap until the next sample tick.
//
// Ports:
//   clk             system clock
//   rst_n           synchronous, active-low reset
//   sample_tick     one-cycle game tick; consumes a latched up press
//   btn_up_raw      asynchronous up/jump pad, active-high
//   btn_down_raw    asynchronous down/duck pad, active-high
//   button_up       debounced up level OR pending latched up press
//   button_down     debounced down level (no latch)
//   up_level        debounced up level, for debug/LED
//   any_press_pulse one-cycle pulse after a debounced rise on either button
module input_conditioner #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_COUNT = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic button_up,
    output logic button_down,
    output logic up_level,
    output logic any_press_pulse
);

    localparam int unsigned NBTN = 2;

    // The cycle that moves the FSM out of LOW/HIGH is the first disagreement
    // cycle, so the filter state covers the remaining DEBOUNCE_COUNT-1 cycles
    // with counts 0..DEBOUNCE_COUNT-2. This gives exactly DEBOUNCE_COUNT
    // consecutive disagreeing samples before the level flips.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 2);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_FILT_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_FILT_L = 2'd3
    } db_state_e;

    logic [NBTN-1:0] raw_c;
    logic [NBTN-1:0] level_c;
    logic [NBTN-1:0] rise_c;

    logic up_latch_q, up_latch_d;
    logic press_pulse_q, press_pulse_d;

    assign raw_c = {btn_down_raw, btn_up_raw};

    // Per-button synchroniser + debouncer (index 0 = up, 1 = down)
    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   synced_c;
        db_state_e              state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   btn_rise_c;

        // Shift chain: stage 0 samples the pad, last stage is the synced level
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], raw_c[g]};
        end

        assign synced_c = sync_q[SYNC_STAGES-1];

        // Debounce next-state logic
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            btn_rise_c = 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (synced_c) begin
                        state_d = ST_FILT_H;
                        cnt_d   = '0;
                    end
                end
                ST_FILT_H: begin
                    if (!synced_c) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = ST_HIGH;
                        cnt_d      = '0;
                        btn_rise_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!synced_c) begin
                        state_d = ST_FILT_L;
                        cnt_d   = '0;
                    end
                end
                ST_FILT_L: begin
                    if (synced_c) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
            level_d = (state_d == ST_HIGH) || (state_d == ST_FILT_L);
        end

        // Per-button registers
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_q  <= '0;
                state_q <= ST_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level_c[g] = level_q;
        assign rise_c[g]  = btn_rise_c;
    end

    // Press latch and pulse; a rise on the tick edge must outlive that tick
    always_comb begin
        up_latch_d = up_latch_q;
        if (sample_tick) begin
            up_latch_d = 1'b0;
        end
        if (rise_c[0]) begin
            up_latch_d = 1'b1;
        end
        press_pulse_d = |rise_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_latch_q    <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            up_latch_q    <= up_latch_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign up_level        = level_c[0];
    assign button_down     = level_c[1];
    assign button_up       = level_c[0] | up_latch_q;
    assign any_press_pulse = press_pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: directed vector table plus hand-written
// sequences for glitches, taps between ticks, set/clear collision and reset.
module tb_input_conditioner;

    logic clk;
    logic rst_n;
    logic sample_tick;
    logic btn_up_raw;
    logic btn_down_raw;
    logic button_up;
    logic button_down;
    logic up_level;
    logic any_press_pulse;

    int checks;
    int failures;

    input_conditioner #(
        .SYNC_STAGES   (2),
        .DEBOUNCE_COUNT(16),
        .CNT_W         (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .btn_up_raw     (btn_up_raw),
        .btn_down_raw   (btn_down_raw),
        .button_up      (button_up),
        .button_down    (button_down),
        .up_level       (up_level),
        .any_press_pulse(any_press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic rst_n;
        logic up;
        logic dn;
        logic tick;
        int   cycles;
        logic e_bu;
        logic e_bd;
        logic e_lvl;
        logic e_pulse;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %b expected %b (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int idx,
                           input logic e_bu, input logic e_bd,
                           input logic e_lvl, input logic e_pulse);
        chk({name, ".button_up"},       idx, button_up,       e_bu);
        chk({name, ".button_down"},     idx, button_down,     e_bd);
        chk({name, ".up_level"},        idx, up_level,        e_lvl);
        chk({name, ".any_press_pulse"}, idx, any_press_pulse, e_pulse);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        sample_tick  = 1'b0;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;

        //            rst  up    dn    tick  cyc  bu    bd    lvl   pulse
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,   2, 1'b0, 1'b0, 1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,  17, 1'b0, 1'b0, 1'b0, 1'b0}; // one edge short
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b1, 1'b1}; // 18th edge: rise
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b1, 1'b0}; // pulse is 1 cycle
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,  50, 1'b1, 1'b0, 1'b1, 1'b0}; // held
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1,   1, 1'b1, 1'b0, 1'b1, 1'b0}; // held across tick
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,  17, 1'b1, 1'b0, 1'b1, 1'b0}; // fall pending
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b0, 1'b0, 1'b0}; // 18th edge: low
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0,  17, 1'b0, 1'b0, 1'b0, 1'b0}; // down filtering
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0,   1, 1'b0, 1'b1, 1'b0, 1'b1}; // down rise
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1,   5, 1'b0, 1'b1, 1'b0, 1'b0}; // tick ignored by down
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0,  17, 1'b0, 1'b1, 1'b0, 1'b0}; // down fall pending
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b0, 1'b0, 1'b0}; // down low, no latch
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0,  18, 1'b1, 1'b1, 1'b1, 1'b1}; // both rise, one pulse
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0,  18, 1'b1, 1'b0, 1'b0, 1'b0}; // latch holds up
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 1'b0, 1'b0, 1'b0, 1'b0}; // tick consumes
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0,   5, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            rst_n        = vecs[i].rst_n;
            btn_up_raw   = vecs[i].up;
            btn_down_raw = vecs[i].dn;
            sample_tick  = vecs[i].tick;
            step(vecs[i].cycles);
            chk_all("vec", i, vecs[i].e_bu, vecs[i].e_bd, vecs[i].e_lvl, vecs[i].e_pulse);
        end
        sample_tick = 1'b0;

        // Glitch: 15 cycles high is one short of the filter, never seen
        btn_up_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1);
            chk_all("glitch_hi", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        btn_up_raw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            chk_all("glitch_lo", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Short tap between ticks 200 cycles apart
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(50);
        btn_up_raw = 1'b1;
        step(30);
        chk("tap.up_level_high", 0, up_level, 1'b1);
        btn_up_raw = 1'b0;
        step(40);
        chk("tap.up_level_low", 0, up_level, 1'b0);
        chk("tap.button_up_latched", 0, button_up, 1'b1);
        step(79);
        chk("tap.button_up_before_tick", 0, button_up, 1'b1);
        sample_tick = 1'b1;
        #1;
        chk("tap.button_up_in_tick", 0, button_up, 1'b1);
        step(1);
        sample_tick = 1'b0;
        chk("tap.button_up_after_tick", 0, button_up, 1'b0);
        step(1);
        chk("tap.button_up_after_tick", 1, button_up, 1'b0);

        // Rise event on the same edge as sample_tick: set wins
        btn_up_raw = 1'b1;
        step(17);
        chk("coll.up_level_pre", 0, up_level, 1'b0);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("coll.up_level", 0, up_level, 1'b1);
        chk("coll.pulse", 0, any_press_pulse, 1'b1);
        btn_up_raw = 1'b0;
        step(18);
        chk("coll.up_level_low", 0, up_level, 1'b0);
        chk("coll.button_up_latched", 0, button_up, 1'b1);
        step(20);
        chk("coll.button_up_latched", 1, button_up, 1'b1);
        sample_tick = 1'b1;
        #1;
        chk("coll.button_up_in_tick", 0, button_up, 1'b1);
        step(1);
        sample_tick = 1'b0;
        chk("coll.button_up_after_tick", 0, button_up, 1'b0);

        // Reset while the down filter is part-way: count restarts from zero
        btn_down_raw = 1'b1;
        step(10);
        chk("rstmid.button_down_pre", 0, button_down, 1'b0);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("rstmid.button_down_rst", 0, button_down, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step(1);
            chk("rstmid.button_down_wait", i, button_down, 1'b0);
        end
        step(1);
        chk("rstmid.button_down_set", 18, button_down, 1'b1);
        chk("rstmid.pulse", 18, any_press_pulse, 1'b1);
        btn_down_raw = 1'b0;
        step(20);
        chk("rstmid.button_down_clear", 0, button_down, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
